// File: rtl/alu_types.sv
// rtl/alu_types.sv - ALU opcode encoding shared by the control path and the ALU
package alu_types;

  typedef enum logic [3:0] {
    ALU_NONE = 4'd0,
    ALU_AND  = 4'd1,
    ALU_OR   = 4'd2,
    ALU_XOR  = 4'd3,
    ALU_SLL  = 4'd4,
    ALU_SRL  = 4'd5,
    ALU_SRA  = 4'd6,
    ALU_ADD  = 4'd7,
    ALU_SUB  = 4'd8,
    ALU_SLT  = 4'd9,
    ALU_SLTU = 4'd10
  } alu_control_t;

endpackage

// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - opcodes, controller states, mux selects and control word
package rv32i_types;
  import alu_types::*;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_R      = 7'b0110011,
    OP_I      = 7'b0010011,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111
  } opcode_e;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
    S_EXEC_R, S_EXEC_I, S_UPPER, S_ALU_WB, S_BRANCH, S_JALR, S_JAL, S_ERROR
  } state_e;

  localparam logic [1:0] SRC_A_PC     = 2'd0;
  localparam logic [1:0] SRC_A_OLD_PC = 2'd1;
  localparam logic [1:0] SRC_A_RS1    = 2'd2;
  localparam logic [1:0] SRC_A_ZERO   = 2'd3;

  localparam logic [1:0] SRC_B_RS2    = 2'd0;
  localparam logic [1:0] SRC_B_IMM    = 2'd1;
  localparam logic [1:0] SRC_B_FOUR   = 2'd2;

  localparam logic [1:0] RES_ALUOUT   = 2'd0;
  localparam logic [1:0] RES_MEMDATA  = 2'd1;
  localparam logic [1:0] RES_LIVE     = 2'd2;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic ADDR_PC     = 1'b0;
  localparam logic ADDR_RESULT = 1'b1;

  // br/jal mark the states whose pc_ena is resolved outside the register
  typedef struct packed {
    alu_control_t alu;
    logic [1:0]   src_a;
    logic [1:0]   src_b;
    logic [1:0]   result_src;
    logic         mem_addr_src;
    logic         reg_write;
    logic         mem_wr_ena;
    logic         error;
    logic         br;
    logic         jal;
  } ctl_t;

  localparam ctl_t CTL_IDLE = '{alu: ALU_ADD, src_a: SRC_A_PC, src_b: SRC_B_RS2,
                                result_src: RES_ALUOUT, mem_addr_src: ADDR_PC,
                                reg_write: 1'b0, mem_wr_ena: 1'b0, error: 1'b0,
                                br: 1'b0, jal: 1'b0};

  localparam ctl_t CTL_FETCH = '{alu: ALU_ADD, src_a: SRC_A_PC, src_b: SRC_B_FOUR,
                                 result_src: RES_LIVE, mem_addr_src: ADDR_PC,
                                 reg_write: 1'b0, mem_wr_ena: 1'b0, error: 1'b0,
                                 br: 1'b0, jal: 1'b0};

  function automatic logic [2:0] imm_sel(input logic [6:0] op);
    case (op)
      OP_STORE:         return IMM_S;
      OP_BRANCH:        return IMM_B;
      OP_LUI, OP_AUIPC: return IMM_U;
      OP_JAL:           return IMM_J;
      default:          return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_multicycle_controller_if.sv
// rtl/rv32i_multicycle_controller_if.sv - controller <-> datapath/memory control bundle
interface rv32i_multicycle_controller_if;
  import alu_types::*;

  logic [31:0]  instr;
  logic         mem_ready;
  logic         alu_equal;
  logic         alu_result_lsb;
  alu_control_t alu_control;
  logic [1:0]   alu_src_a;
  logic [1:0]   alu_src_b;
  logic [1:0]   result_src;
  logic [2:0]   imm_src;
  logic         mem_addr_src;
  logic         pc_ena;
  logic         ir_write;
  logic         reg_write;
  logic         mem_wr_ena;
  logic         error;

  modport master (
    input  instr, mem_ready, alu_equal, alu_result_lsb,
    output alu_control, alu_src_a, alu_src_b, result_src, imm_src, mem_addr_src,
           pc_ena, ir_write, reg_write, mem_wr_ena, error
  );

  modport slave (
    output instr, mem_ready, alu_equal, alu_result_lsb,
    input  alu_control, alu_src_a, alu_src_b, result_src, imm_src, mem_addr_src,
           pc_ena, ir_write, reg_write, mem_wr_ena, error
  );

endinterface

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - funct3/funct7 to ALU opcode for R-type and I-type ALU ops
module alu_decoder
  import alu_types::*;
(
  input  logic [2:0]   funct3,
  input  logic         funct7_5,
  input  logic         is_r_type,
  output alu_control_t alu_control
);

  // funct7[5] selects SUB only for R-type; shifts honour it in both forms (SRA/SRAI)
  always_comb begin
    alu_control = ALU_ADD;
    case (funct3)
      3'b000: alu_control = (is_r_type && funct7_5) ? ALU_SUB : ALU_ADD;
      3'b001: alu_control = ALU_SLL;
      3'b010: alu_control = ALU_SLT;
      3'b011: alu_control = ALU_SLTU;
      3'b100: alu_control = ALU_XOR;
      3'b101: alu_control = funct7_5 ? ALU_SRA : ALU_SRL;
      3'b110: alu_control = ALU_OR;
      default: alu_control = ALU_AND;
    endcase
  end

endmodule

// File: rtl/rv32i_multicycle_controller.sv
// rtl/rv32i_multicycle_controller.sv - multi-cycle RV32I control FSM
module rv32i_multicycle_controller
  import alu_types::*, rv32i_types::*;
#(
  parameter int N = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  rv32i_multicycle_controller_if.master bus
);

  logic [N-1:0] ir;
  logic [6:0]   opcode;
  logic [2:0]   funct3;
  logic         funct7_5;
  logic         unused_bits;

  assign ir          = bus.instr;
  assign opcode      = ir[6:0];
  assign funct3      = ir[14:12];
  assign funct7_5    = ir[30];
  assign unused_bits = ^{ir[31], ir[29:15], ir[11:7]};

  state_e       state, next_state;
  ctl_t         ctl, next_ctl;
  alu_control_t dec_alu;
  logic         taken;

  alu_decoder u_alu_decoder (
    .funct3      (funct3),
    .funct7_5    (funct7_5),
    .is_r_type   (opcode == OP_R),
    .alu_control (dec_alu)
  );

  // Phase sequencing; mem_ready only matters in the fetch and data-memory states
  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:     if (bus.mem_ready) next_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: next_state = S_MEM_ADR;
          OP_R:              next_state = S_EXEC_R;
          OP_I:              next_state = S_EXEC_I;
          OP_LUI, OP_AUIPC:  next_state = S_UPPER;
          OP_BRANCH:         next_state = S_BRANCH;
          OP_JAL:            next_state = S_JAL;
          OP_JALR:           next_state = S_JALR;
          default:           next_state = S_ERROR;
        endcase
      end
      S_MEM_ADR:   next_state = (opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (bus.mem_ready) next_state = S_MEM_WB;
      S_MEM_WB:    next_state = S_FETCH;
      S_MEM_WRITE: if (bus.mem_ready) next_state = S_FETCH;
      S_EXEC_R, S_EXEC_I, S_UPPER, S_JAL: next_state = S_ALU_WB;
      S_ALU_WB:    next_state = S_FETCH;
      S_BRANCH:    next_state = (funct3[2:1] == 2'b01) ? S_ERROR : S_FETCH;
      S_JALR:      next_state = S_JAL;
      default:     next_state = S_ERROR;
    endcase
  end

  // Control word for the state being entered, so outputs come straight from flops
  always_comb begin
    next_ctl = CTL_IDLE;
    case (next_state)
      S_FETCH:     next_ctl = CTL_FETCH;
      S_DECODE: begin
        next_ctl.src_a = SRC_A_OLD_PC;
        next_ctl.src_b = SRC_B_IMM;
      end
      S_MEM_ADR, S_JALR: begin
        next_ctl.src_a = SRC_A_RS1;
        next_ctl.src_b = SRC_B_IMM;
      end
      S_MEM_READ:  next_ctl.mem_addr_src = ADDR_RESULT;
      S_MEM_WB: begin
        next_ctl.result_src = RES_MEMDATA;
        next_ctl.reg_write  = 1'b1;
      end
      S_MEM_WRITE: begin
        next_ctl.mem_addr_src = ADDR_RESULT;
        next_ctl.mem_wr_ena   = 1'b1;
      end
      S_EXEC_R: begin
        next_ctl.src_a = SRC_A_RS1;
        next_ctl.alu   = dec_alu;
      end
      S_EXEC_I: begin
        next_ctl.src_a = SRC_A_RS1;
        next_ctl.src_b = SRC_B_IMM;
        next_ctl.alu   = dec_alu;
      end
      S_UPPER: begin
        next_ctl.src_a = (opcode == OP_LUI) ? SRC_A_ZERO : SRC_A_OLD_PC;
        next_ctl.src_b = SRC_B_IMM;
      end
      S_ALU_WB:    next_ctl.reg_write = 1'b1;
      S_BRANCH: begin
        next_ctl.src_a = SRC_A_RS1;
        next_ctl.br    = 1'b1;
        case (funct3[2:1])
          2'b10:   next_ctl.alu = ALU_SLT;
          2'b11:   next_ctl.alu = ALU_SLTU;
          default: next_ctl.alu = ALU_SUB;
        endcase
      end
      S_JAL: begin
        next_ctl.src_a = SRC_A_OLD_PC;
        next_ctl.src_b = SRC_B_FOUR;
        next_ctl.jal   = 1'b1;
      end
      default:     next_ctl.error = 1'b1;
    endcase
  end

  // State and registered Moore outputs advance together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
      ctl   <= CTL_FETCH;
    end else begin
      state <= next_state;
      ctl   <= next_ctl;
    end
  end

  // Branch outcome from the live ALU compare; the reserved funct3 codes never take
  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:         taken = bus.alu_equal;
      3'b001:         taken = ~bus.alu_equal;
      3'b100, 3'b110: taken = bus.alu_result_lsb;
      3'b101, 3'b111: taken = ~bus.alu_result_lsb;
      default:        taken = 1'b0;
    endcase
  end

  assign bus.alu_control  = ctl.alu;
  assign bus.alu_src_a    = ctl.src_a;
  assign bus.alu_src_b    = ctl.src_b;
  assign bus.result_src   = ctl.result_src;
  assign bus.mem_addr_src = ctl.mem_addr_src;
  assign bus.reg_write    = ctl.reg_write;
  assign bus.mem_wr_ena   = ctl.mem_wr_ena;
  assign bus.error        = ctl.error;
  assign bus.imm_src      = imm_sel(opcode);
  assign bus.ir_write     = rst_n && (state == S_FETCH) && bus.mem_ready;
  assign bus.pc_ena       = (rst_n && (state == S_FETCH) && bus.mem_ready) ||
                            ctl.jal || (ctl.br && taken);

endmodule

// File: tb/tb_rv32i_multicycle_controller.sv
// tb/tb_rv32i_multicycle_controller.sv - bench for the multi-cycle RV32I controller
module tb_rv32i_multicycle_controller;

  localparam int X = -1;
  localparam int R = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rv32i_multicycle_controller_if bus();

  rv32i_multicycle_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic        mr;
    logic [18:0] exp;
    logic [18:0] mask;
    logic [63:0] nm;
  } step_t;

  typedef struct {
    logic [31:0] instr;
    int          wf;
    int          wm;
    logic        eq;
    logic        lsb;
  } vec_t;

  step_t sb[$];
  vec_t  vt[18];
  int    total = 0;
  int    bad = 0;
  int    cur_imm = 0;

  function automatic logic [18:0] act_word();
    return {bus.alu_control, bus.alu_src_a, bus.alu_src_b, bus.result_src, bus.imm_src,
            bus.mem_addr_src, bus.pc_ena, bus.ir_write, bus.reg_write, bus.mem_wr_ena,
            bus.error};
  endfunction

  task automatic check(input logic [63:0] nm, input logic [18:0] exp, input logic [18:0] mask);
    logic [18:0] a;
    a = act_word();
    total++;
    if ((a & mask) !== (exp & mask)) begin
      bad++;
      $display("FAIL %0s instr=%h got=%h want=%h care=%h", nm, bus.instr, a, exp, mask);
    end
  endtask

  task automatic put(inout logic [18:0] e, inout logic [18:0] m, input int v, input int lo, input int w);
    if (v >= 0)
      for (int i = 0; i < w; i++) begin
        e[lo+i] = v[i];
        m[lo+i] = 1'b1;
      end
  endtask

  task automatic add(input int mr, input int alu, input int a, input int b, input int res,
                     input int mas, input int pc, input int ir, input int rw, input int mw,
                     input int err, input logic [63:0] nm);
    step_t s;
    s.exp = '0;
    s.mask = '0;
    put(s.exp, s.mask, alu, 15, 4);
    put(s.exp, s.mask, a, 13, 2);
    put(s.exp, s.mask, b, 11, 2);
    put(s.exp, s.mask, res, 9, 2);
    put(s.exp, s.mask, cur_imm, 6, 3);
    put(s.exp, s.mask, mas, 5, 1);
    put(s.exp, s.mask, pc, 4, 1);
    put(s.exp, s.mask, ir, 3, 1);
    put(s.exp, s.mask, rw, 2, 1);
    put(s.exp, s.mask, mw, 1, 1);
    put(s.exp, s.mask, err, 0, 1);
    s.mr = (mr == R) ? 1'($urandom_range(0, 1)) : 1'(mr);
    s.nm = nm;
    sb.push_back(s);
  endtask

  function automatic int imm_of(input logic [6:0] op);
    case (op)
      7'b0000011, 7'b0010011, 7'b1100111: return 0;
      7'b0100011: return 1;
      7'b1100011: return 2;
      7'b0110111, 7'b0010111: return 3;
      7'b1101111: return 4;
      default: return X;
    endcase
  endfunction

  function automatic int exp_alu(input logic [2:0] f3, input logic f7b, input logic isr);
    case (f3)
      3'd0: return (isr && f7b) ? 8 : 7;
      3'd1: return 4;
      3'd2: return 9;
      3'd3: return 10;
      3'd4: return 3;
      3'd5: return f7b ? 6 : 5;
      3'd6: return 2;
      default: return 1;
    endcase
  endfunction

  // Expected per-cycle outputs for one instruction, straight from the phase list
  task automatic gen(input vec_t v);
    logic [6:0] op;
    logic [2:0] f3;
    int         tk;
    op = v.instr[6:0];
    f3 = v.instr[14:12];
    cur_imm = imm_of(op);
    bus.instr = v.instr;
    bus.alu_equal = v.eq;
    bus.alu_result_lsb = v.lsb;
    repeat (v.wf) add(0, 7, 0, 2, 2, 0, 0, 0, 0, 0, 0, "FETCHW");
    add(1, 7, 0, 2, 2, 0, 1, 1, 0, 0, 0, "FETCH");
    add(R, 7, 1, 1, X, X, 0, 0, 0, 0, 0, "DECODE");
    case (op)
      7'b0000011, 7'b0100011: begin
        add(R, 7, 2, 1, X, X, 0, 0, 0, 0, 0, "MEMADR");
        if (op == 7'b0000011) begin
          repeat (v.wm) add(0, X, X, X, 0, 1, 0, 0, 0, 0, 0, "MEMRDW");
          add(1, X, X, X, 0, 1, 0, 0, 0, 0, 0, "MEMRD");
          add(R, X, X, X, 1, X, 0, 0, 1, 0, 0, "MEMWB");
        end else begin
          repeat (v.wm) add(0, X, X, X, 0, 1, 0, 0, 0, 1, 0, "MEMWRW");
          add(1, X, X, X, 0, 1, 0, 0, 0, 1, 0, "MEMWR");
        end
      end
      7'b0110011: begin
        add(R, exp_alu(f3, v.instr[30], 1'b1), 2, 0, X, X, 0, 0, 0, 0, 0, "EXECR");
        add(R, X, X, X, 0, X, 0, 0, 1, 0, 0, "ALUWB");
      end
      7'b0010011: begin
        add(R, exp_alu(f3, v.instr[30], 1'b0), 2, 1, X, X, 0, 0, 0, 0, 0, "EXECI");
        add(R, X, X, X, 0, X, 0, 0, 1, 0, 0, "ALUWB");
      end
      7'b0110111, 7'b0010111: begin
        add(R, 7, (op == 7'b0110111) ? 3 : 1, 1, X, X, 0, 0, 0, 0, 0, "UPPER");
        add(R, X, X, X, 0, X, 0, 0, 1, 0, 0, "ALUWB");
      end
      7'b1100011: begin
        if (f3 == 3'd2 || f3 == 3'd3) begin
          add(R, X, 2, 0, 0, X, X, 0, 0, 0, 0, "BRANCH");
          repeat (3) add(R, X, X, X, X, X, 0, 0, 0, 0, 1, "ERROR");
        end else begin
          case (f3)
            3'd0: tk = v.eq ? 1 : 0;
            3'd1: tk = v.eq ? 0 : 1;
            3'd4, 3'd6: tk = v.lsb ? 1 : 0;
            default: tk = v.lsb ? 0 : 1;
          endcase
          add(R, (f3[2:1] == 2'b10) ? 9 : (f3[2:1] == 2'b11) ? 10 : 8,
              2, 0, 0, X, tk, 0, 0, 0, 0, "BRANCH");
        end
      end
      7'b1101111, 7'b1100111: begin
        if (op == 7'b1100111) add(R, 7, 2, 1, X, X, 0, 0, 0, 0, 0, "JALR");
        add(R, 7, 1, 2, 0, X, 1, 0, 0, 0, 0, "JAL");
        add(R, X, X, X, 0, X, 0, 0, 1, 0, 0, "ALUWB");
      end
      default: repeat (3) add(R, X, X, X, X, X, 0, 0, 0, 0, 1, "ERROR");
    endcase
  endtask

  // Apply queued stimulus one cycle at a time and compare on the falling edge
  task automatic run_steps(input int n);
    step_t s;
    for (int k = 0; k < n && sb.size() > 0; k++) begin
      s = sb.pop_front();
      bus.mem_ready = s.mr;
      @(negedge clk);
      check(s.nm, s.exp, s.mask);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reset_pulse(input logic [63:0] nm);
    rst_n = 1'b0;
    #1;
    check(nm, 19'h0, 19'h1F);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    vt[0]  = '{32'h002081B3, 0, 0, 1'b0, 1'b0};
    vt[1]  = '{32'h40208133, 2, 0, 1'b0, 1'b0};
    vt[2]  = '{32'h4020D1B3, 0, 0, 1'b0, 1'b0};
    vt[3]  = '{32'h0020B1B3, 0, 0, 1'b0, 1'b0};
    vt[4]  = '{32'h40008093, 0, 0, 1'b0, 1'b0};
    vt[5]  = '{32'h4010D093, 0, 0, 1'b0, 1'b0};
    vt[6]  = '{32'h0010D093, 0, 0, 1'b0, 1'b0};
    vt[7]  = '{32'h00012083, 0, 3, 1'b0, 1'b0};
    vt[8]  = '{32'h00112023, 0, 2, 1'b0, 1'b0};
    vt[9]  = '{32'h000010B7, 0, 0, 1'b0, 1'b0};
    vt[10] = '{32'h00001097, 0, 0, 1'b0, 1'b0};
    vt[11] = '{32'h00209063, 0, 0, 1'b1, 1'b0};
    vt[12] = '{32'h00209063, 1, 0, 1'b0, 1'b1};
    vt[13] = '{32'h00208063, 0, 0, 1'b1, 1'b0};
    vt[14] = '{32'h0020E063, 0, 0, 1'b0, 1'b1};
    vt[15] = '{32'h0020D063, 0, 0, 1'b0, 1'b1};
    vt[16] = '{32'h000000EF, 0, 0, 1'b0, 1'b0};
    vt[17] = '{32'h000100E7, 0, 0, 1'b0, 1'b0};

    bus.instr = 32'h00000013;
    bus.mem_ready = 1'b1;
    bus.alu_equal = 1'b0;
    bus.alu_result_lsb = 1'b0;
    rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("RESET", 19'h0, 19'h1F);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      gen(vt[i]);
      run_steps(64);
    end

    gen('{32'h0000007F, 0, 0, 1'b0, 1'b0});
    run_steps(64);
    reset_pulse("RSTERR");
    gen(vt[0]);
    run_steps(64);

    gen('{32'h0020A063, 0, 0, 1'b1, 1'b1});
    run_steps(64);
    reset_pulse("RSTBR");

    gen('{32'h00112023, 0, 5, 1'b0, 1'b0});
    run_steps(4);
    sb.delete();
    #1;
    check("MWPRE", 19'h2, 19'h3);
    rst_n = 1'b0;
    #1;
    check("MWRST", 19'h0, 19'h1F);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    gen(vt[16]);
    run_steps(64);
    add(0, 7, 0, 2, 2, 0, 0, 0, 0, 0, 0, "ENDFETCH");
    run_steps(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv32i_multicycle_controller.md
# rv32i_multicycle_controller

Multi-cycle control FSM that drives the ALU and the datapath of the RV32I core. It decodes the latched instruction, sequences fetch/decode/execute/memory/writeback phases, and issues `alu_control_t` opcodes together with operand-select and write-enable strobes. It also closes the loop on the ALU's `equal` output and result LSB to resolve branches. It waits on a single-bit memory ready handshake.

## Interface
Parameters:
- N, 32, datapath width. Fixed; used only as a constant.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr  in  32  instruction register contents (opcode [6:0], funct3 [14:12], funct7 [31:25]).
- mem_ready  in  1  memory has completed the current access this cycle.
- alu_equal  in  1  ALU `equal` (a == b).
- alu_result_lsb  in  1  bit 0 of live ALU result (SLT/SLTU outcome).
- alu_control  out  alu_control_t  ALU opcode: AND=1, OR=2, XOR=3, SLL=4, SRL=5, SRA=6, ADD=7, SUB=8, SLT=9, SLTU=10.
- alu_src_a  out  2  0=PC, 1=old PC, 2=rs1 register, 3=zero.
- alu_src_b  out  2  0=rs2 register, 1=immediate, 2=constant 4.
- result_src  out  2  0=ALU-out register, 1=memory read data, 2=live ALU result.
- imm_src  out  3  0=I, 1=S, 2=B, 3=U, 4=J.
- mem_addr_src  out  1  0=PC, 1=result bus.
- pc_ena, ir_write, reg_write, mem_wr_ena  out  1 each  write strobes.
- error  out  1  sticky illegal-opcode flag.

## Operation
- Moore outputs, except `pc_ena`, `ir_write`, and the branch `pc_ena`, which are gated as noted below. In every state, all strobes not listed are 0.
- S_FETCH: mem_addr_src=0; a=PC; b=4; ADD; result_src=2. `ir_write`=`pc_ena`=mem_ready. Stay until mem_ready, then go to S_DECODE.
- S_DECODE: a=old PC; b=imm (B or J); ADD, which precomputes the branch/JAL target into ALU-out. Dispatch on opcode:
  - load/store → S_MEM_ADR
  - R → S_EXEC_R
  - I-ALU → S_EXEC_I
  - LUI/AUIPC → S_UPPER
  - branch → S_BRANCH
  - JAL → S_JAL
  - JALR → S_JALR
  - anything else → S_ERROR
- S_MEM_ADR: a=rs1; b=imm; ADD. Go to S_MEM_READ (load) or S_MEM_WRITE (store).
- S_MEM_READ: mem_addr_src=1; result_src=0. Stay until mem_ready, then go to S_MEM_WB.
- S_MEM_WB: result_src=1; reg_write=1. Go to S_FETCH.
- S_MEM_WRITE: mem_addr_src=1; result_src=0; mem_wr_ena=1. Stay until mem_ready, then go to S_FETCH.
- S_EXEC_R: a=rs1; b=rs2; opcode from alu_decoder. Go to S_ALU_WB.
- S_EXEC_I: a=rs1; b=imm. funct7[5] is honoured only for SRAI (funct3=101); ADDI never yields SUB. Go to S_ALU_WB.
- S_UPPER: b=imm(U); ADD. a=3 (zero) for LUI, a=1 (old PC) for AUIPC. Go to S_ALU_WB.
- S_ALU_WB: result_src=0; reg_write=1. Go to S_FETCH.
- S_BRANCH: a=rs1; b=rs2; result_src=0.
  - BEQ/BNE use SUB and alu_equal.
  - BLT/BGE use SLT and alu_result_lsb.
  - BLTU/BGEU use SLTU and alu_result_lsb.
  - pc_ena=taken.
  - Go to S_FETCH.
  - funct3 010/011 → S_ERROR.
- S_JALR: a=rs1; b=imm(I); ADD, which loads the target into ALU-out. Go to S_JAL.
- S_JAL: result_src=0; pc_ena=1, so PC takes the target. a=old PC; b=4; ADD. Go to S_ALU_WB, which writes the link.
- S_ERROR: error=1; no strobes asserted. Exit only by reset.

## Timing
- Reset (async, rst_n=0):
  - state=S_FETCH; error=0.
  - All strobes read 0 while reset is asserted.
  - First fetch begins on the first rising edge after deassertion.
- Cycle counts with zero-wait memory (mem_ready=1 on first cycle):
  - R/I/U: 4
  - load: 5
  - store: 4
  - branch: 3
  - JAL: 4
  - JALR: 5
- Each wait cycle with mem_ready=0 adds one cycle. Strobes hold steady while waiting.
- mem_ready asserted outside memory states is ignored.
- Reset asserted mid-instruction: the FSM returns to S_FETCH immediately. Any partially issued `mem_wr_ena`/`reg_write` drops in the same delta.
- imm_src is decoded combinationally from opcode in every state.
- Next-state logic is registered on clk.

## Structure
- Package `rv32i_types`:
  - opcode enum: LOAD=0000011, STORE=0100011, R=0110011, I=0010011, LUI=0110111, AUIPC=0010111, BRANCH=1100011, JAL=1101111, JALR=1100111.
  - controller state enum.
  - mux-select constants.
- `alu_control_t` stays in `alu_types`.
- Sub-module `alu_decoder`: combinational mapping of (funct3, funct7[5], is_r_type) to alu_control_t. Unit-testable on its own.

## Test plan
- Reset held low, then released → all strobes 0 while low, S_FETCH thereafter; error=0.
- ADD x3,x1,x2 (0x002081B3), mem_ready=1 → 4 cycles; EXEC_R alu_control=7, b=0; ALU_WB reg_write=1.
- LW with mem_ready low for 3 cycles in S_MEM_READ → strobes stable; total 8 cycles; reg_write in MEM_WB with result_src=1.
- BNE with alu_equal=1 → pc_ena=0 in S_BRANCH; repeat with alu_equal=0 → pc_ena=1.
- BLTU with alu_result_lsb=1 → alu_control=10 and pc_ena=1.
- JAL, then an illegal opcode 0x0000007F:
  - JAL → S_JAL pc_ena=1, then ALU_WB reg_write=1.
  - Illegal opcode → error=1 held until rst_n pulse; reset pulse during S_MEM_WRITE drops mem_wr_ena at once.
